// File: rtl/mux2_arb_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter:
// FSM state encodings, mux select polarity, default hold limit and
// the hold counter width helper.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_A = 2'd1,
        ST_GRANT_B = 2'd2
    } arb_state_t;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

    localparam int DEF_HOLD_MAX = 4;

    // Counter must represent 0..HOLD_MAX-1 with headroom; clog2+1 bits.
    function automatic int hold_cnt_w(input int hold_max);
        return $clog2(hold_max) + 1;
    endfunction

endpackage

// File: rtl/mux2.sv
// Single-bit 2-to-1 multiplexer: i_sel=1 passes i_a, i_sel=0 passes i_b.
module mux2 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_sel,
    output logic o_y
);

    assign o_y = i_sel ? i_a : i_b;

endmodule

// File: rtl/mux2_rr_arbiter_hold_counter.sv
// Grant-hold counter: synchronous clear, increment, saturation at the
// terminal value HOLD_MAX-1, with a flag raised at that terminal value.
module arb_hold_counter #(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_term
);

    logic [CNT_W-1:0] r_cnt;

    assign o_term = (r_cnt == CNT_W'(HOLD_MAX - 1));
    assign o_cnt  = r_cnt;

    // Clear wins over increment; increment stops at the terminal value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_term) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one 2-to-1 operand mux between requesters
// A and B, with the selected operand registered toward the ALU input.
// Consecutive grants are capped at HOLD_MAX cycles.
// Optional build macro MUX2_ARB_LOCK_EN adds a `lock` input that
// suppresses the hold expiry while the owner keeps requesting.
module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int HOLD_MAX = DEF_HOLD_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
`ifdef MUX2_ARB_LOCK_EN
    input  logic             lock,
`endif
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             select,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int CNT_W = hold_cnt_w(HOLD_MAX);

    arb_state_t       r_state;
    logic             r_last;
    logic             r_gnt_a;
    logic             r_gnt_b;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    arb_state_t       w_next_state;
    logic             w_next_last;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic             w_term;
    logic             w_expire;
    logic             w_lock;
    logic             w_xfer;
    logic [CNT_W-1:0] w_hold_cnt;
    logic [WIDTH-1:0] w_mux_out;

`ifdef MUX2_ARB_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    // While locked, the counter saturates at its terminal value instead of
    // forcing re-arbitration.
    assign w_expire = w_term && !w_lock;

    arb_hold_counter #(
        .HOLD_MAX (HOLD_MAX),
        .CNT_W    (CNT_W)
    ) u_hold (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_cnt_clr),
        .i_inc  (w_cnt_inc),
        .o_cnt  (w_hold_cnt),
        .o_term (w_term)
    );

    // Next-state, round-robin memory and hold counter control.
    always_comb begin
        w_next_state = r_state;
        w_next_last  = r_last;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_clr = 1'b1;
                if (req_a && (!req_b || r_last == SEL_B)) begin
                    w_next_state = ST_GRANT_A;
                end else if (req_b) begin
                    w_next_state = ST_GRANT_B;
                end
            end
            ST_GRANT_A: begin
                if (req_a && !w_expire) begin
                    w_cnt_inc = 1'b1;
                end else begin
                    w_cnt_clr = 1'b1;
                    if (req_b) begin
                        w_next_state = ST_GRANT_B;
                        w_next_last  = SEL_A;
                    end else if (!req_a) begin
                        w_next_state = ST_IDLE;
                        w_next_last  = SEL_A;
                    end
                end
            end
            ST_GRANT_B: begin
                if (req_b && !w_expire) begin
                    w_cnt_inc = 1'b1;
                end else begin
                    w_cnt_clr = 1'b1;
                    if (req_a) begin
                        w_next_state = ST_GRANT_A;
                        w_next_last  = SEL_B;
                    end else if (!req_b) begin
                        w_next_state = ST_IDLE;
                        w_next_last  = SEL_B;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_cnt_clr    = 1'b1;
            end
        endcase
    end

    // The owner moves data only while it is still requesting.
    assign w_xfer = (r_gnt_a && req_a) || (r_gnt_b && req_b);

    // Operand mux built from one mux2 per bit, steered by the grant.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mux
        mux2 u_mux (
            .i_a   (data_a[gi]),
            .i_b   (data_b[gi]),
            .i_sel (r_gnt_a),
            .o_y   (w_mux_out[gi])
        );
    end

    // State, grants and the output operand register update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_last      <= SEL_B;
            r_gnt_a     <= 1'b0;
            r_gnt_b     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_state     <= w_next_state;
            r_last      <= w_next_last;
            r_gnt_a     <= (w_next_state == ST_GRANT_A);
            r_gnt_b     <= (w_next_state == ST_GRANT_B);
            r_out_valid <= w_xfer;
            if (w_xfer) begin
                r_out_data <= w_mux_out;
            end
        end
    end

    assign gnt_a     = r_gnt_a;
    assign gnt_b     = r_gnt_b;
    assign select    = r_gnt_a;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 2-to-1 datapath multiplexer between two requesters, A and B.
- Drives the mux `select` line (1 selects A, 0 selects B) and registers the selected operand toward the 4-bit ALU input stage.
- Caps consecutive grants to one requester at HOLD_MAX cycles so neither side starves.

Parameters:
- WIDTH, 4, operand width of data_a/data_b/out_data.
- HOLD_MAX, 4, max consecutive grant cycles per requester before forced re-arbitration; legal range 1..15.

Ports:
- clk  input  1  system clock; one clock, all state on rising edge.
- rst  input  1  reset; synchronous and active-high.
- req_a  input  1  requester A wants a transfer this cycle.
- req_b  input  1  requester B wants a transfer this cycle.
- data_a  input  WIDTH  requester A operand.
- data_b  input  WIDTH  requester B operand.
- gnt_a  output  1  A owns the mux (registered).
- gnt_b  output  1  B owns the mux (registered).
- select  output  1  mux select; 1 = A, 0 = B; equals gnt_a.
- out_valid  output  1  out_data holds a transferred operand.
- out_data  output  WIDTH  registered selected operand.
- busy  output  1  state != IDLE.

Behaviour:
- Reset values: gnt_a=0, gnt_b=0, select=0, out_valid=0, out_data=0, busy=0, state=IDLE, hold_cnt=0, last=B, so A wins the first tie.
- rst asserted mid-grant: the next edge returns everything to the reset values and drops any in-flight transfer; out_valid=0.
- States: IDLE, GRANT_A, GRANT_B; grants are one-hot or zero, never both.
- Transfer: in a cycle with gnt_x=1 and req_x=1, the next cycle has out_valid=1 and out_data=data_x (latency 1). Otherwise out_valid=0 next cycle and out_data holds its value.
- IDLE transitions:
  - only req_a -> GRANT_A.
  - only req_b -> GRANT_B.
  - both -> the one != last.
  - neither -> stay IDLE.
  - First grant is visible the cycle after the request, so a transfer needs 2 cycles from first req.
- GRANT_x transitions (y = the other requester):
  - req_x high and hold_cnt < HOLD_MAX-1 -> stay; hold_cnt++.
  - req_x low, or hold_cnt == HOLD_MAX-1 -> re-arbitrate:
    - req_y high -> GRANT_y; last=x; hold_cnt=0.
    - else req_x high (expired, no competitor) -> stay GRANT_x; hold_cnt=0.
    - else -> IDLE; last=x.
- Switching A->B directly gives zero idle cycles between grants; select changes on the same edge as the grants.
- hold_cnt width is clog2(HOLD_MAX)+1. With HOLD_MAX=1, the grant alternates every cycle while both request.

Optional Feature:
- Macro: MUX2_ARB_LOCK_EN.
- With it: adds input `lock` (1 bit). While `lock`=1 and the current owner's req is high, the HOLD_MAX expiry is suppressed (hold_cnt saturates at HOLD_MAX-1) and ownership is kept. A drop of req_x still releases. Used for multi-cycle ALU sequences.
- Without it: no `lock` port; fairness is always enforced.

Decomposition:
- Shared package mux2_arb_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_GRANT_A=2'd1, ST_GRANT_B=2'd2.
  - SEL_A=1'b1, SEL_B=1'b0.
  - default HOLD_MAX.
- One natural sub-module, arb_hold_counter: a clear/increment/saturate counter with a terminal flag at HOLD_MAX-1.
- The output datapath instantiates the existing mux2 per bit (WIDTH copies) fed by `select`, followed by the out_data register.

Test Plan:
- Reset then req_a=1 only, data_a=4'h5 -> cycle1 gnt_a=1, select=1; cycle2 out_valid=1, out_data=4'h5.
- req_a=req_b=1 from IDLE after reset, HOLD_MAX=4 -> gnt_a for 4 cycles, then gnt_b for 4 cycles, alternating; never both high; out_data tracks the owner with 1-cycle lag.
- Only req_b held 10 cycles -> gnt_b stays continuous across the expiry boundary (hold_cnt wraps to 0); no IDLE gap.
- GRANT_A, req_a drops with req_b=1, data_b=4'hC -> next cycle gnt_b=1, select=0; one cycle later out_data=4'hC; out_valid=0 in the gap cycle.
- rst pulsed while GRANT_B with out_valid=1 -> next cycle all outputs 0, state IDLE; then both requesting -> A granted first.
- With MUX2_ARB_LOCK_EN, lock=1, both requesting -> gnt_a held 10+ cycles; lock=0 -> B granted within HOLD_MAX cycles.
